// File: rtl/column_dropper_if.sv
// Bundle between the key/switch front end, the column dropper and the top row
// of board cells.
interface column_dropper_if #(
    parameter int COLS = 16
) ();
    logic                    drop;
    logic [$clog2(COLS)-1:0] col_sel;
    logic                    lock;
    logic [COLS-1:0]         topG;
    logic [COLS-1:0]         topR;
    logic [COLS-1:0]         aboveG;
    logic [COLS-1:0]         aboveR;
    logic                    player;
    logic                    busy;
    logic                    reject;

    // Key side plus board top row: drives requests and cell state, watches pulses.
    modport master (
        output drop, col_sel, lock, topG, topR,
        input  aboveG, aboveR, player, busy, reject
    );

    // The dropper itself.
    modport slave (
        input  drop, col_sel, lock, topG, topR,
        output aboveG, aboveR, player, busy, reject
    );
endinterface

// File: rtl/column_dropper.sv
// Token launcher for the Connect Four board: injects one Red/Green pulse into
// the selected column's top cell, waits for the token to land, then passes the turn.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// stIdle   | waiting for a drop edge; accepts or rejects it
// stInject | one-hot above pulse is on the wire for this single cycle
// stSettle | token falling; cnt runs 0..SETTLE-1, then turn changes
module column_dropper #(
    parameter int COLS   = 16,
    parameter int ROWS   = 16,
    parameter int SETTLE = ROWS + 1
) (
    input  logic             clk,
    input  logic             RST,
    column_dropper_if.slave  bus
);
    localparam int CNTW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        stIdle   = 2'd0,
        stInject = 2'd1,
        stSettle = 2'd2
    } state_t;

    state_t            state, stateNext;
    logic [COLS-1:0]   aboveGQ, aboveGNext;
    logic [COLS-1:0]   aboveRQ, aboveRNext;
    logic              playerQ, playerNext;
    logic              rejectQ, rejectNext;
    logic              busyQ;
    logic [CNTW-1:0]   cnt, cntNext;
    logic              dropQ;

    logic              req;
    logic              colValid;
    logic              topOccupied;

    assign req      = bus.drop & ~dropQ;
    assign colValid = (int'(bus.col_sel) < COLS);
    // An out-of-range column is treated like a full one so it is never indexed.
    assign topOccupied = colValid ? (bus.topG[bus.col_sel] | bus.topR[bus.col_sel]) : 1'b1;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state   <= stIdle;
            aboveGQ <= '0;
            aboveRQ <= '0;
            playerQ <= 1'b0;
            rejectQ <= 1'b0;
            busyQ   <= 1'b0;
            cnt     <= '0;
            dropQ   <= 1'b1;
        end else begin
            state   <= stateNext;
            aboveGQ <= aboveGNext;
            aboveRQ <= aboveRNext;
            playerQ <= playerNext;
            rejectQ <= rejectNext;
            busyQ   <= (stateNext != stIdle);
            cnt     <= cntNext;
            dropQ   <= bus.drop;
        end
    end

    always_comb begin
        stateNext  = state;
        aboveGNext = '0;
        aboveRNext = '0;
        playerNext = playerQ;
        rejectNext = 1'b0;
        cntNext    = cnt;
        case (state)
            stIdle: begin
                if (req) begin
                    if (!bus.lock && colValid && !topOccupied) begin
                        stateNext = stInject;
                        if (playerQ) aboveGNext[bus.col_sel] = 1'b1;
                        else         aboveRNext[bus.col_sel] = 1'b1;
                    end else begin
                        rejectNext = 1'b1;
                    end
                end
            end
            stInject: begin
                stateNext = stSettle;
                cntNext   = '0;
            end
            stSettle: begin
                if (cnt == CNTW'(SETTLE - 1)) begin
                    stateNext  = stIdle;
                    playerNext = ~playerQ;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            default: begin
                stateNext = stIdle;
            end
        endcase
    end

    assign bus.aboveG = aboveGQ;
    assign bus.aboveR = aboveRQ;
    assign bus.player = playerQ;
    assign bus.busy   = busyQ;
    assign bus.reject = rejectQ;
endmodule

// File: tb/tb_column_dropper.sv
// Directed bench for column_dropper with a small falling-token board model
// feeding the top-row occupancy back to the dropper.
module tb_column_dropper;
    localparam int COLS = 16;
    localparam int ROWS = 16;
    localparam int BOUND = 100;

    logic clk;
    logic RST;
    column_dropper_if #(.COLS(COLS)) bus ();

    column_dropper #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;
    int expPlayer = 0;

    // Board model: each column is a stack, index 0 is the bottom cell.
    int   height [COLS];
    logic stk    [COLS][ROWS];   // 1 = Green, 0 = Red
    int   pulseCount  = 0;
    int   rejectCount = 0;
    int   overlapErr  = 0;
    logic [COLS-1:0] topGm, topRm;

    always @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int c = 0; c < COLS; c++) height[c] = 0;
        end else begin
            if ((bus.aboveG | bus.aboveR) != '0) begin
                pulseCount++;
                if (((bus.aboveG & bus.aboveR) != '0) || ($countones(bus.aboveG | bus.aboveR) != 1))
                    overlapErr++;
                for (int c = 0; c < COLS; c++) begin
                    if ((bus.aboveG[c] | bus.aboveR[c]) && height[c] < ROWS) begin
                        stk[c][height[c]] = bus.aboveG[c];
                        height[c]++;
                    end
                end
            end
            if (bus.reject) rejectCount++;
        end
    end

    always_comb begin
        topGm = '0;
        topRm = '0;
        for (int c = 0; c < COLS; c++) begin
            if (height[c] == ROWS) begin
                topGm[c] = stk[c][ROWS-1];
                topRm[c] = ~stk[c][ROWS-1];
            end
        end
    end
    assign bus.topG = topGm;
    assign bus.topR = topRm;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dropOnce(input int c);
        bus.col_sel = 4'(c);
        bus.drop = 1'b1;
        tick();
        bus.drop = 1'b0;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (bus.busy && n < BOUND) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [COLS-1:0] colBit(input int c);
        logic [COLS-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        bus.drop = 1'b1; bus.col_sel = 4'd2; bus.lock = 1'b0;
        RST = 1'b0;
        #23;
        compared++;
        if ({bus.aboveG, bus.aboveR, bus.player, bus.busy, bus.reject} !== '0) begin
            failed++; $display("FAIL reset_outputs: got G=%h R=%h p=%b busy=%b rej=%b want all 0",
                               bus.aboveG, bus.aboveR, bus.player, bus.busy, bus.reject);
        end
        RST = 1'b1;
        repeat (4) tick();
        compared++;
        if (pulseCount !== 0 || rejectCount !== 0 || bus.busy !== 1'b0) begin
            failed++; $display("FAIL held_drop_through_reset: pulses=%0d rejects=%0d busy=%b want 0 0 0",
                               pulseCount, rejectCount, bus.busy);
        end
        compared++;
        if (bus.player !== 1'b0) begin
            failed++; $display("FAIL reset_player: got %b want 0", bus.player);
        end
        bus.drop = 1'b0;
        tick();
    endtask

    task automatic test_first_drop();
        int n;
        int p0;
        p0 = pulseCount;
        dropOnce(3);
        compared++;
        if (bus.aboveR !== 16'h0008 || bus.aboveG !== 16'h0000) begin
            failed++; $display("FAIL first_pulse: got R=%h G=%h want R=0008 G=0000", bus.aboveR, bus.aboveG);
        end
        waitIdle(n);
        compared++;
        if (n !== 18) begin
            failed++; $display("FAIL busy_length: got %0d cycles want 18", n);
        end
        compared++;
        if (pulseCount - p0 !== 1) begin
            failed++; $display("FAIL pulse_width: got %0d pulse cycles want 1", pulseCount - p0);
        end
        expPlayer = 1;
        compared++;
        if (bus.player !== 1'b1) begin
            failed++; $display("FAIL turn_to_green: got %b want 1", bus.player);
        end
    endtask

    task automatic test_second_drop();
        int n;
        dropOnce(3);
        compared++;
        if (bus.aboveG !== 16'h0008 || bus.aboveR !== 16'h0000) begin
            failed++; $display("FAIL green_pulse: got G=%h R=%h want G=0008 R=0000", bus.aboveG, bus.aboveR);
        end
        waitIdle(n);
        compared++;
        if (height[3] !== 2 || stk[3][0] !== 1'b0 || stk[3][1] !== 1'b1) begin
            failed++; $display("FAIL stack_col3: got h=%0d bot=%b next=%b want h=2 bot=0 next=1",
                               height[3], stk[3][0], stk[3][1]);
        end
        expPlayer = 0;
        compared++;
        if (bus.player !== 1'b0) begin
            failed++; $display("FAIL turn_to_red: got %b want 0", bus.player);
        end
    endtask

    task automatic test_full_column();
        int n;
        int p0, r0;
        for (int i = 0; i < ROWS; i++) begin
            dropOnce(0);
            waitIdle(n);
            if (n >= BOUND) begin
                compared++; failed++;
                $display("FAIL fill_timeout: drop %0d still busy after %0d cycles", i, n);
            end
        end
        compared++;
        if (height[0] !== ROWS || bus.player !== 1'b0) begin
            failed++; $display("FAIL fill_col0: got h=%0d p=%b want h=16 p=0", height[0], bus.player);
        end
        p0 = pulseCount; r0 = rejectCount;
        dropOnce(0);
        compared++;
        if (bus.reject !== 1'b1 || (bus.aboveG | bus.aboveR) !== '0 || bus.busy !== 1'b0) begin
            failed++; $display("FAIL full_reject: got rej=%b above=%h busy=%b want 1 0000 0",
                               bus.reject, bus.aboveG | bus.aboveR, bus.busy);
        end
        tick();
        compared++;
        if (bus.reject !== 1'b0 || rejectCount - r0 !== 1 || pulseCount !== p0) begin
            failed++; $display("FAIL full_reject_pulse: got rej=%b rejects=%0d pulses=%0d want 0 1 0",
                               bus.reject, rejectCount - r0, pulseCount - p0);
        end
        compared++;
        if (bus.player !== 1'b0) begin
            failed++; $display("FAIL full_player: got %b want 0", bus.player);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int p0, r0;
        p0 = pulseCount; r0 = rejectCount;
        dropOnce(5);
        tick();
        bus.drop = 1'b1; tick();
        bus.drop = 1'b0; tick();
        bus.drop = 1'b1; tick(); tick();
        bus.drop = 1'b0;
        waitIdle(n);
        repeat (3) tick();
        expPlayer = 1 - expPlayer;
        compared++;
        if (pulseCount - p0 !== 1 || rejectCount !== r0) begin
            failed++; $display("FAIL busy_edges_ignored: got pulses=%0d rejects=%0d want 1 0",
                               pulseCount - p0, rejectCount - r0);
        end
        compared++;
        if (bus.player !== 1'(expPlayer) || height[5] !== 1) begin
            failed++; $display("FAIL busy_single_toggle: got p=%b h=%0d want p=%0d h=1",
                               bus.player, height[5], expPlayer);
        end
    endtask

    task automatic test_lock();
        int n;
        int p0;
        p0 = pulseCount;
        bus.lock = 1'b1;
        dropOnce(6);
        tick();
        compared++;
        if (rejectCount < 1 || pulseCount !== p0 || bus.busy !== 1'b0) begin
            failed++; $display("FAIL lock_reject: got pulses=%0d busy=%b want 0 0", pulseCount - p0, bus.busy);
        end
        bus.lock = 1'b0;
        tick();
        dropOnce(6);
        compared++;
        if ((expPlayer == 1 ? bus.aboveG : bus.aboveR) !== colBit(6)) begin
            failed++; $display("FAIL unlock_pulse: got G=%h R=%h want bit 6 for player %0d",
                               bus.aboveG, bus.aboveR, expPlayer);
        end
        repeat (3) tick();
        bus.lock = 1'b1;
        waitIdle(n);
        expPlayer = 1 - expPlayer;
        compared++;
        if (bus.player !== 1'(expPlayer) || n >= BOUND) begin
            failed++; $display("FAIL lock_in_flight: got p=%b n=%0d want p=%0d", bus.player, n, expPlayer);
        end
        bus.lock = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_settle();
        int n;
        if (expPlayer == 0) begin
            dropOnce(8);
            waitIdle(n);
            expPlayer = 1;
        end
        compared++;
        if (bus.player !== 1'b1) begin
            failed++; $display("FAIL pre_reset_player: got %b want 1", bus.player);
        end
        dropOnce(7);
        repeat (5) tick();
        compared++;
        if (bus.busy !== 1'b1) begin
            failed++; $display("FAIL mid_settle_busy: got %b want 1", bus.busy);
        end
        #2 RST = 1'b0;
        #1;
        compared++;
        if (bus.busy !== 1'b0 || bus.player !== 1'b0 || (bus.aboveG | bus.aboveR) !== '0) begin
            failed++; $display("FAIL async_reset: got busy=%b p=%b above=%h want 0 0 0000",
                               bus.busy, bus.player, bus.aboveG | bus.aboveR);
        end
        #4 RST = 1'b1;
        repeat (3) tick();
        compared++;
        if (bus.busy !== 1'b0 || bus.player !== 1'b0) begin
            failed++; $display("FAIL post_reset_idle: got busy=%b p=%b want 0 0", bus.busy, bus.player);
        end
    endtask

    initial begin
        test_reset();
        test_first_drop();
        test_second_drop();
        test_full_column();
        test_back_to_back();
        test_lock();
        test_reset_mid_settle();
        compared++;
        if (overlapErr !== 0) begin
            failed++; $display("FAIL one_hot_pulse: got %0d bad pulse cycles want 0", overlapErr);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
